rf_wb_queue: RTL and testbench
==============================

Name: rf_wb_queue

Overview:
- Write-side front end of the 32x32 register file, which has one write port.
- Accepts results from two producers: port A (main pipeline WB stage) and port B (multi-cycle mul/div unit). Both may complete in the same cycle.
- Buffers results in a small in-order FIFO and drains one write per cycle onto the register file's we/waddr/wdata port.
- Provides bypass lookup so decode can see values still queued or in flight to the register file.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset (asserted when 0)
a_valid  in  1  port A write request
a_ready  out  1  port A can accept this cycle
a_addr  in  AW  port A destination register
a_data  in  DW  port A result
b_valid  in  1  port B write request
b_ready  out  1  port B can accept this cycle
b_addr  in  AW  port B destination register
b_data  in  DW  port B result
rf_we  out  1  register file write enable (registered)
rf_waddr  out  AW  register file write address (registered)
rf_wdata  out  DW  register file write data (registered)
fwd_raddr1  in  AW  bypass lookup address 1
fwd_hit1  out  1  a pending write to fwd_raddr1 exists
fwd_data1  out  DW  youngest pending data for fwd_raddr1
fwd_raddr2  in  AW  bypass lookup address 2
fwd_hit2  out  1  same as fwd_hit1, for lookup 2
fwd_data2  out  DW  same as fwd_data1, for lookup 2
idle  out  1  FIFO empty and rf_we low

Behaviour:
- Reset (rst=0, takes effect asynchronously): count, read and write pointers cleared; rf_we=0, rf_waddr=0, rf_wdata=0. Queued entries are discarded. Reset arriving mid-stream simply drops pending writes.
- Ready signals depend only on registered count, never on valid:
  - a_ready = (count <= DEPTH-1)
  - b_ready = (count <= DEPTH-2)
  - This guarantees two enqueues in one cycle always fit.
- Handshake: a transfer happens when valid&&ready at posedge. Producers hold valid, addr and data stable until accepted.
- Enqueue:
  - A request to address 0 is accepted (ready honoured) but is not enqueued.
  - When A and B both transfer in one cycle, the A entry is written first (older), then the B entry.
  - Up to 2 enqueues per cycle.
- Drain: each posedge, if count>0 (count as registered before this edge), the head is popped into rf_we/rf_waddr/rf_wdata with rf_we<=1. Otherwise rf_we<=0, and waddr/wdata hold their previous values.
- Count update: count_next = count + enqueues - pop. Enqueue and pop in the same cycle are legal. Pointers wrap modulo DEPTH.
- Latency, empty queue: accepted at edge N -> rf_we high after edge N+1 -> register file updated at edge N+2.
- Bypass (combinational):
  - Search all valid FIFO entries plus the output register (when rf_we=1).
  - The hit selects the youngest match: newest FIFO entry first, then the output register.
  - Address 0 never hits; fwd_data is 0 on a miss.
  - Same-cycle incoming A/B requests are not searched.
- Ordering: writes reach the register file in acceptance order, so the last write to a register wins.
- idle = (count==0) && !rf_we.

Decomposition:
- Shared package: AW, DW, DEPTH defaults, and a wb_entry typedef {addr[AW], data[DW]}.
- One sub-module is natural: rf_wb_fifo (dual-push, single-pop circular buffer exposing entry valid/addr/data arrays for the bypass search).
- The top level holds the ready logic, output register and bypass priority mux.

Test Plan:
- Single write: A writes x5=0x1234_5678 into an empty queue at edge N -> rf_we=1, rf_waddr=5, rf_wdata=0x12345678 after edge N+1; rf_we=0 after edge N+2; idle=1 after that.
- Dual push: A(x3=0xA) and B(x3=0xB) in the same cycle -> two consecutive rf_we cycles, x3=0xA then x3=0xB; fwd_raddr1=3 returns hit=1, data=0xB while either is pending.
- Backpressure: hold A and B valid with DEPTH=4 and count=3 -> a_ready=1, b_ready=0; after one pop with no push, count=2 and b_ready=1; no entry is lost or duplicated over 20 random requests.
- Address zero: A writes x0=0xFFFF_FFFF -> a_ready honoured, no rf_we pulse, fwd lookup of 0 gives hit=0, data=0.
- Bypass from output register: x7=0x55 sitting in the output register (rf_we=1) with an empty FIFO -> fwd_hit2=1, fwd_data2=0x55; the following cycle hit=0.
- Reset mid-operation: 3 entries queued, rst driven 0 between edges -> rf_we drops to 0 immediately (asynchronously), a_ready=b_ready=1 after release, no stale writes emitted.

Source files
------------

// File: rtl/rf_wb_queue_pkg.sv
// rtl/rf_wb_queue_pkg.sv - shared defaults and entry type for the register-file write-back queue
package rf_wb_queue_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - dual-push single-pop circular buffer, entries exposed oldest-first
module rf_wb_fifo
  import rf_wb_queue_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push0_i,
  input  logic [AW-1:0]             push0_addr_i,
  input  logic [DW-1:0]             push0_data_i,
  input  logic                      push1_i,
  input  logic [AW-1:0]             push1_addr_i,
  input  logic [DW-1:0]             push1_data_i,
  input  logic                      pop_i,
  output logic [CW-1:0]             count_o,
  output logic [DEPTH-1:0]          ent_valid_o,
  output logic [DEPTH-1:0][AW-1:0]  ent_addr_o,
  output logic [DEPTH-1:0][DW-1:0]  ent_data_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr1_idx;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  // push1 lands behind push0 when both are present, otherwise at the write pointer
  assign wr1_idx = wr_ptr_q + PW'(push0_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    cnt_d    = cnt_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0_i) begin
      addr_q[wr_ptr_q] <= push0_addr_i;
      data_q[wr_ptr_q] <= push0_data_i;
    end
    if (push1_i) begin
      addr_q[wr1_idx] <= push1_addr_i;
      data_q[wr1_idx] <= push1_data_i;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] idx;
    assign idx            = rd_ptr_q + PW'(i);
    assign ent_valid_o[i] = CW'(i) < cnt_q;
    assign ent_addr_o[i]  = addr_q[idx];
    assign ent_data_o[i]  = data_q[idx];
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/rf_wb_queue.sv
// rtl/rf_wb_queue.sv - two-producer write-back queue feeding the single register-file write port
module rf_wb_queue
  import rf_wb_queue_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] fwd_raddr1,
  output logic          fwd_hit1,
  output logic [DW-1:0] fwd_data1,
  input  logic [AW-1:0] fwd_raddr2,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data2,
  output logic          idle
);

  logic [CW-1:0]            count;
  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic                     a_push, b_push, pop;
  logic                     rf_we_q;
  logic [AW-1:0]            rf_waddr_q;
  logic [DW-1:0]            rf_wdata_q;

  // Readiness comes from registered occupancy only, so a dual push always has room
  assign a_ready = count <= CW'(DEPTH - 1);
  assign b_ready = count <= CW'(DEPTH - 2);
  assign a_push  = a_valid && a_ready && (a_addr != '0);
  assign b_push  = b_valid && b_ready && (b_addr != '0);
  assign pop     = count != '0;

  rf_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push0_i      (a_push),
    .push0_addr_i (a_addr),
    .push0_data_i (a_data),
    .push1_i      (b_push),
    .push1_addr_i (b_addr),
    .push1_data_i (b_data),
    .pop_i        (pop),
    .count_o      (count),
    .ent_valid_o  (ent_valid),
    .ent_addr_o   (ent_addr),
    .ent_data_o   (ent_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= pop;
      if (pop) begin
        rf_waddr_q <= ent_addr[0];
        rf_wdata_q <= ent_data[0];
      end
    end
  end

  // Output register is oldest; later FIFO slots are younger and override earlier matches
  function automatic logic [DW:0] lookup(
    input logic [AW-1:0]             raddr,
    input logic [DEPTH-1:0]          vld,
    input logic [DEPTH-1:0][AW-1:0]  adr,
    input logic [DEPTH-1:0][DW-1:0]  dat,
    input logic                      out_we,
    input logic [AW-1:0]             out_addr,
    input logic [DW-1:0]             out_data
  );
    logic [DW:0] res;
    res = '0;
    if (raddr != '0) begin
      if (out_we && out_addr == raddr) res = {1'b1, out_data};
      for (int i = 0; i < DEPTH; i++)
        if (vld[i] && adr[i] == raddr) res = {1'b1, dat[i]};
    end
    return res;
  endfunction

  assign {fwd_hit1, fwd_data1} = lookup(fwd_raddr1, ent_valid, ent_addr, ent_data,
                                        rf_we_q, rf_waddr_q, rf_wdata_q);
  assign {fwd_hit2, fwd_data2} = lookup(fwd_raddr2, ent_valid, ent_addr, ent_data,
                                        rf_we_q, rf_waddr_q, rf_wdata_q);

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign idle     = (count == '0) && !rf_we_q;

endmodule

// File: tb/tb_rf_wb_queue.sv
// tb/tb_rf_wb_queue.sv - randomized self-checking bench for rf_wb_queue against a queue model
module tb_rf_wb_queue;
  import rf_wb_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_raddr1, fwd_raddr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic        idle;

  int vectors = 0;
  int errors  = 0;

  // Reference: accepted writes in order, plus the register-file port as last driven
  wb_entry_t   mq[$];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  rf_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_raddr1(fwd_raddr1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_raddr2(fwd_raddr2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] m_lookup(input logic [4:0] ra);
    logic [32:0] r;
    r = '0;
    if (ra != 5'd0) begin
      if (m_we && m_waddr == ra) r = {1'b1, m_wdata};
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].addr == ra) r = {1'b1, mq[i].data};
    end
    return r;
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endfunction

  // One clock: starts and ends at a negedge
  task automatic step(input logic av, input logic [4:0] aad, input logic [31:0] ad,
                      input logic bv, input logic [4:0] bad, input logic [31:0] bd,
                      input logic [4:0] ra1, input logic [4:0] ra2,
                      output logic acc_a, output logic acc_b);
    logic        exp_ar, exp_br, exp_idle;
    logic [32:0] l1, l2;
    wb_entry_t   e;
    a_valid = av; a_addr = aad; a_data = ad;
    b_valid = bv; b_addr = bad; b_data = bd;
    fwd_raddr1 = ra1; fwd_raddr2 = ra2;
    #1;
    exp_ar = mq.size() <= DEPTH - 1;
    exp_br = mq.size() <= DEPTH - 2;
    l1 = m_lookup(ra1);
    l2 = m_lookup(ra2);
    vectors++;
    if (a_ready !== exp_ar) begin errors++; $display("FAIL a_ready: got %b want %b", a_ready, exp_ar); end
    vectors++;
    if (b_ready !== exp_br) begin errors++; $display("FAIL b_ready: got %b want %b", b_ready, exp_br); end
    vectors++;
    if ({fwd_hit1, fwd_data1} !== l1) begin
      errors++; $display("FAIL fwd1 x%0d: got %b/%h want %b/%h", ra1, fwd_hit1, fwd_data1, l1[32], l1[31:0]);
    end
    vectors++;
    if ({fwd_hit2, fwd_data2} !== l2) begin
      errors++; $display("FAIL fwd2 x%0d: got %b/%h want %b/%h", ra2, fwd_hit2, fwd_data2, l2[32], l2[31:0]);
    end
    acc_a = av && exp_ar;
    acc_b = bv && exp_br;
    @(posedge clk);
    #1;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_waddr = e.addr; m_wdata = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (acc_a && aad != 5'd0) mq.push_back('{addr: aad, data: ad});
    if (acc_b && bad != 5'd0) mq.push_back('{addr: bad, data: bd});
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    exp_idle = (mq.size() == 0) && !m_we;
    vectors++;
    if (rf_we !== m_we) begin errors++; $display("FAIL rf_we: got %b want %b", rf_we, m_we); end
    vectors++;
    if (rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
      errors++; $display("FAIL rf_port: got x%0d=%h want x%0d=%h", rf_waddr, rf_wdata, m_waddr, m_wdata);
    end
    vectors++;
    if (idle !== exp_idle) begin errors++; $display("FAIL idle: got %b want %b", idle, exp_idle); end
  endtask

  task automatic nop(input logic [4:0] ra1, input logic [4:0] ra2);
    logic x, y;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra1, ra2, x, y);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && !(idle === 1'b1); i++) nop(5'd1, 5'd2);
    vectors++;
    if (idle !== 1'b1) begin errors++; $display("FAIL drain: idle got %b want 1", idle); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
    fwd_raddr1 = 0; fwd_raddr2 = 0;
    m_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_port: got %b x%0d=%h want 0 x0=0", rf_we, rf_waddr, rf_wdata);
    end
    vectors++;
    if (idle !== 1'b1 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++; $display("FAIL reset_status: got idle=%b ar=%b br=%b want 1 1 1", idle, a_ready, b_ready);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    logic x, y;
    step(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, x, y);
    nop(5'd5, 5'd0);
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL single_write: got %b x%0d=%h want 1 x5=12345678", rf_we, rf_waddr, rf_wdata);
    end
    nop(5'd5, 5'd0);
    vectors++;
    if (rf_we !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL single_done: got we=%b idle=%b want 0 1", rf_we, idle);
    end
  endtask

  task automatic test_dual_push();
    logic x, y;
    step(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 5'd3, 5'd3, x, y);
    fwd_raddr1 = 5'd3; #1;
    vectors++;
    if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hB) begin
      errors++; $display("FAIL dual_fwd: got %b/%h want 1/0000000b", fwd_hit1, fwd_data1);
    end
    nop(5'd3, 5'd0);
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hA) begin
      errors++; $display("FAIL dual_first: got %b x%0d=%h want 1 x3=a", rf_we, rf_waddr, rf_wdata);
    end
    nop(5'd3, 5'd0);
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hB) begin
      errors++; $display("FAIL dual_second: got %b x%0d=%h want 1 x3=b", rf_we, rf_waddr, rf_wdata);
    end
    drain();
  endtask

  task automatic run_random(input int n, input int amax);
    logic pa, pb, acc_a, acc_b;
    logic [4:0]  aad, bad;
    logic [31:0] ad, bd;
    pa = 0; pb = 0; aad = 0; bad = 0; ad = 0; bd = 0;
    for (int i = 0; i < n; i++) begin
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1; aad = 5'($urandom_range(0, amax)); ad = $urandom;
      end
      if (!pb && $urandom_range(0, 3) != 0) begin
        pb = 1; bad = 5'($urandom_range(0, amax)); bd = $urandom;
      end
      step(pa, aad, ad, pb, bad, bd, 5'($urandom_range(0, amax)), 5'($urandom_range(0, amax)),
           acc_a, acc_b);
      if (acc_a) pa = 0;
      if (acc_b) pb = 0;
    end
    // finish any held request so the producer contract is honoured, then drain
    for (int i = 0; i < 10 && (pa || pb); i++) begin
      step(pa, aad, ad, pb, bad, bd, 5'd1, 5'd2, acc_a, acc_b);
      if (acc_a) pa = 0;
      if (acc_b) pb = 0;
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic x, y;
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd1, 5'd2, x, y);
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4, x, y);
    #1;
    vectors++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full: got ar=%b br=%b want 1 0", a_ready, b_ready);
    end
    nop(5'd2, 5'd4);
    vectors++;
    if (b_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got br=%b want 1", b_ready); end
    drain();
    run_random(20, 6);
  endtask

  task automatic test_addr_zero();
    logic acc_a, y;
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, acc_a, y);
    vectors++;
    if (acc_a !== 1'b1) begin errors++; $display("FAIL zero_accept: got %b want 1", acc_a); end
    nop(5'd0, 5'd0);
    vectors++;
    if (rf_we !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL zero_nowrite: got we=%b idle=%b want 0 1", rf_we, idle);
    end
  endtask

  task automatic test_bypass_outreg();
    logic x, y;
    step(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7, x, y);
    nop(5'd0, 5'd7);
    fwd_raddr2 = 5'd7; #1;
    vectors++;
    if (rf_we !== 1'b1 || fwd_hit2 !== 1'b1 || fwd_data2 !== 32'h55) begin
      errors++; $display("FAIL outreg_hit: got we=%b %b/%h want 1 1/00000055", rf_we, fwd_hit2, fwd_data2);
    end
    nop(5'd0, 5'd7);
    vectors++;
    if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'd0) begin
      errors++; $display("FAIL outreg_gone: got %b/%h want 0/00000000", fwd_hit2, fwd_data2);
    end
  endtask

  task automatic test_reset_mid();
    logic x, y;
    step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 5'd9, 5'd10, x, y);
    step(1'b1, 5'd11, 32'hBB, 1'b1, 5'd12, 32'hCC, 5'd11, 5'd12, x, y);
    #2 rst = 1'b0;
    #1;
    m_reset();
    vectors++;
    if (rf_we !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL reset_async: got we=%b idle=%b want 0 1", rf_we, idle);
    end
    @(negedge clk);
    rst = 1'b1;
    vectors++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got ar=%b br=%b want 1 1", a_ready, b_ready);
    end
    for (int i = 0; i < 4; i++) nop(5'd11, 5'd12);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_dual_push();
    test_backpressure();
    test_addr_zero();
    test_bypass_outreg();
    test_reset_mid();
    run_random(300, 7);
    run_random(200, 31);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
